// File: rtl/anim_pkg.sv
// Shared types, playback-mode encodings and the one-hot decode helper
// used by the animation frame sequencer.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Playback modes; the unused 2'b11 encoding falls through to loop.
    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // One bit of a one-hot decode: high when bit position pos is the selected index.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return (idx == pos);
    endfunction

endpackage

// File: rtl/anim_frame_sequencer_if.sv
// Control/status bundle between the sprite pipeline controller and the
// frame sequencer. The controller drives the master side.
interface anim_frame_sequencer_if #(
    parameter int NUM_FRAMES = 2,
    parameter int HOLD_W     = 6,
    parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
);
    logic                  Run;
    logic                  restart;
    logic                  frame_tick;
    logic [1:0]            mode;
    logic [HOLD_W-1:0]     hold_frames;
    logic [FRAME_W-1:0]    frame_idx;
    logic [NUM_FRAMES-1:0] frame_sel;
    logic                  frame_adv;
    logic                  done;
    logic                  busy;

    modport master (
        output Run, restart, frame_tick, mode, hold_frames,
        input  frame_idx, frame_sel, frame_adv, done, busy
    );

    modport slave (
        input  Run, restart, frame_tick, mode, hold_frames,
        output frame_idx, frame_sel, frame_adv, done, busy
    );
endinterface

// File: rtl/anim_hold_counter.sv
// Counts video-frame ticks for the current animation frame and flags the
// tick that completes the hold period. A hold of 0 behaves like 1.
module anim_hold_counter #(
    parameter int HOLD_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic              expire_o
);
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_eff;
    logic [HOLD_W-1:0] terminal;

    assign hold_eff = (hold_i == '0) ? HOLD_W'(1) : hold_i;
    assign terminal = hold_eff - HOLD_W'(1);
    assign expire_o = en_i && (cnt_q == terminal);

    // Tick counter: cleared on request, wraps to zero on the expiring tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= expire_o ? '0 : cnt_q + HOLD_W'(1);
        end
    end
endmodule

// File: rtl/anim_frame_sequencer.sv
// Sprite animation frame sequencer: steps a frame index every N video
// frames in loop, one-shot or ping-pong order with pause and restart.
module anim_frame_sequencer
    import anim_pkg::*;
#(
    parameter int NUM_FRAMES = 2,
    parameter int HOLD_W     = 6,
    parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    anim_frame_sequencer_if.slave  bus
);
    localparam logic [FRAME_W-1:0] LAST_IDX = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ONE      = FRAME_W'(1);

    state_t                state_q;
    logic [FRAME_W-1:0]    idx_q;
    logic                  dir_up_q;
    logic [1:0]            mode_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [NUM_FRAMES-1:0] sel_q;
    logic                  adv_q;
    logic                  done_q;
    logic                  busy_q;

    logic [FRAME_W-1:0]    idx_d;
    logic                  dir_up_d;
    logic                  adv_d;
    logic                  last_d;
    logic [NUM_FRAMES-1:0] sel_d;

    logic start_play;
    logic cnt_clr;
    logic cnt_en;
    logic expire;

    // Leaving IDLE and restart both start a fresh hold period; only
    // un-preempted ticks while actively playing are counted.
    assign start_play = (state_q == IDLE) && bus.Run;
    assign cnt_clr    = bus.restart || start_play;
    assign cnt_en     = (state_q == PLAY) && bus.Run && bus.frame_tick && !bus.restart;

    anim_hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold (
        .clk      (Clk),
        .rst_n    (Reset),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .hold_i   (hold_q),
        .expire_o (expire)
    );

    // Candidate next frame/direction if the current hold period expires.
    always_comb begin
        idx_d    = idx_q;
        dir_up_d = dir_up_q;
        adv_d    = 1'b0;
        last_d   = 1'b0;
        case (mode_q)
            MODE_ONESHOT: begin
                if (idx_q < LAST_IDX) begin
                    idx_d = idx_q + ONE;
                    adv_d = 1'b1;
                end else begin
                    last_d = 1'b1;
                end
            end
            MODE_PINGPONG: begin
                if (NUM_FRAMES > 1) begin
                    adv_d = 1'b1;
                    if (dir_up_q) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d    = idx_q - ONE;
                            dir_up_d = 1'b0;
                        end else begin
                            idx_d = idx_q + ONE;
                        end
                    end else begin
                        if (idx_q == '0) begin
                            idx_d    = idx_q + ONE;
                            dir_up_d = 1'b1;
                        end else begin
                            idx_d = idx_q - ONE;
                        end
                    end
                end
            end
            default: begin
                adv_d = 1'b1;
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ONE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_sel
        assign sel_d[gi] = onehot_bit(32'(idx_d), gi);
    end

    // Playback FSM with registered frame index, select and status pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dir_up_q <= 1'b1;
            mode_q   <= MODE_LOOP;
            hold_q   <= '0;
            sel_q    <= NUM_FRAMES'(1);
            adv_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            adv_q  <= 1'b0;
            done_q <= 1'b0;
            if (bus.restart) begin
                idx_q    <= '0;
                dir_up_q <= 1'b1;
                sel_q    <= NUM_FRAMES'(1);
                mode_q   <= bus.mode;
                hold_q   <= bus.hold_frames;
                state_q  <= bus.Run ? PLAY : IDLE;
                busy_q   <= bus.Run;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.Run) begin
                            mode_q  <= bus.mode;
                            hold_q  <= bus.hold_frames;
                            state_q <= PLAY;
                            busy_q  <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (!bus.Run) begin
                            state_q <= PAUSE;
                        end else if (expire) begin
                            if (last_d) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                idx_q    <= idx_d;
                                dir_up_q <= dir_up_d;
                                sel_q    <= sel_d;
                                adv_q    <= adv_d;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.Run) begin
                            state_q <= PLAY;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.frame_idx = idx_q;
    assign bus.frame_sel = sel_q;
    assign bus.frame_adv = adv_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Bench for the frame sequencer: a playback model based on a count of
// completed hold periods, checked every cycle, plus literal expectations.
module tb_anim_frame_sequencer;
    localparam int N  = 4;
    localparam int HW = 6;
    localparam int FW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anim_frame_sequencer_if #(.NUM_FRAMES(N), .HOLD_W(HW), .FRAME_W(FW)) bus ();

    anim_frame_sequencer #(.NUM_FRAMES(N), .HOLD_W(HW), .FRAME_W(FW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;
    int adv_seen  = 0;
    int done_seen = 0;

    // Model: phase 0 idle, 1 play, 2 pause, 3 done; m_p = completed advances.
    int m_phase = 0, m_cnt = 0, m_p = 0, m_mode = 0, m_hold = 0;
    int e_idx = 0, e_adv = 0, e_done = 0, e_busy = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int idx_of(input int mode, input int p);
        int per, r;
        if (mode == 1) return p;
        if (mode == 2) begin
            per = 2 * (N - 1);
            r   = p % per;
            return (r < N) ? r : per - r;
        end
        return p % N;
    endfunction

    task automatic model_reset;
        m_phase = 0; m_cnt = 0; m_p = 0;
        e_idx = 0; e_adv = 0; e_done = 0; e_busy = 0;
    endtask

    task automatic model_clock;
        int h;
        e_adv  = 0;
        e_done = 0;
        if (bus.restart) begin
            m_mode = bus.mode; m_hold = bus.hold_frames;
            m_p = 0; m_cnt = 0;
            m_phase = bus.Run ? 1 : 0;
        end else begin
            case (m_phase)
                0: if (bus.Run) begin
                    m_mode = bus.mode; m_hold = bus.hold_frames;
                    m_p = 0; m_cnt = 0; m_phase = 1;
                end
                1: if (!bus.Run) begin
                    m_phase = 2;
                end else if (bus.frame_tick) begin
                    h = (m_hold == 0) ? 1 : m_hold;
                    m_cnt++;
                    if (m_cnt == h) begin
                        m_cnt = 0;
                        if (m_mode == 1 && m_p == N - 1) begin
                            e_done = 1; m_phase = 3;
                        end else begin
                            m_p++; e_adv = 1;
                        end
                    end
                end
                2: if (bus.Run) m_phase = 1;
                default: ;
            endcase
        end
        e_idx  = idx_of(m_mode, m_p);
        e_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_clock();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_idx",  int'(bus.frame_idx), e_idx);
            check("cyc_sel",  int'(bus.frame_sel), 1 << e_idx);
            check("cyc_adv",  int'(bus.frame_adv), e_adv);
            check("cyc_done", int'(bus.done),      e_done);
            check("cyc_busy", int'(bus.busy),      e_busy);
            if (bus.frame_adv) adv_seen++;
            if (bus.done)      done_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick;
        @(posedge clk); #1 bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.frame_tick = 1'b0;
        $display("tick: idx=%0d sel=%0d adv=%0d done=%0d busy=%0d",
                 bus.frame_idx, bus.frame_sel, bus.frame_adv, bus.done, bus.busy);
    endtask

    task automatic do_restart(input logic run, input logic [1:0] md, input logic [HW-1:0] hd);
        @(posedge clk); #1;
        bus.restart = 1'b1; bus.Run = run; bus.mode = md; bus.hold_frames = hd;
        @(posedge clk); #1 bus.restart = 1'b0;
        $display("restart: run=%0d mode=%0d hold=%0d", run, md, hd);
    endtask

    int exp_loop[10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    int sel_loop[10] = '{1, 2, 2, 4, 4, 8, 8, 1, 1, 2};
    int exp_one[6]   = '{1, 2, 3, 3, 3, 3};
    int exp_pp[8]    = '{1, 2, 3, 2, 1, 0, 1, 2};
    int a0, d0;

    initial begin
        bus.Run = 1'b0; bus.restart = 1'b0; bus.frame_tick = 1'b0;
        bus.mode = 2'b00; bus.hold_frames = 6'd2;
        @(posedge clk); #1;
        check("rst_idx",  int'(bus.frame_idx), 0);
        check("rst_sel",  int'(bus.frame_sel), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_adv",  int'(bus.frame_adv), 0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        bus.Run = 1'b1;
        idle(1);

        // Loop, hold 2
        a0 = adv_seen;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("loop_idx%0d", i), int'(bus.frame_idx), exp_loop[i]);
            check($sformatf("loop_sel%0d", i), int'(bus.frame_sel), sel_loop[i]);
        end
        idle(1);
        check("loop_adv_count", adv_seen - a0, 5);

        // One-shot, hold 1
        do_restart(1'b1, 2'b01, 6'd1);
        a0 = adv_seen; d0 = done_seen;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("one_idx%0d", i), int'(bus.frame_idx), exp_one[i]);
            if (i == 3) check("one_done_pulse", int'(bus.done), 1);
        end
        idle(1);
        check("one_done_count", done_seen - d0, 1);
        check("one_adv_count", adv_seen - a0, 3);
        check("one_busy", int'(bus.busy), 0);

        // Ping-pong, hold 1
        do_restart(1'b1, 2'b10, 6'd1);
        a0 = adv_seen;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("pp_idx%0d", i), int'(bus.frame_idx), exp_pp[i]);
        end
        idle(1);
        check("pp_adv_count", adv_seen - a0, 8);

        // Pause: 2 ticks, tick dropped with Run falling, 5 ignored, resume + 1
        do_restart(1'b1, 2'b00, 6'd3);
        tick(); tick();
        @(posedge clk); #1 bus.Run = 1'b0; bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.frame_tick = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pause_idx", int'(bus.frame_idx), 0);
        check("pause_busy", int'(bus.busy), 1);
        @(posedge clk); #1 bus.Run = 1'b1;
        tick();
        check("resume_idx", int'(bus.frame_idx), 1);

        // hold_frames = 0 with back-to-back ticks
        do_restart(1'b1, 2'b00, 6'd0);
        @(posedge clk); #1 bus.frame_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        check("hold0_b2b_idx", int'(bus.frame_idx), 3);

        // Restart coincident with a tick at idx 2 (hold_cnt mid-period)
        do_restart(1'b1, 2'b00, 6'd2);
        repeat (5) tick();
        check("pre_rst_idx", int'(bus.frame_idx), 2);
        @(posedge clk); #1 bus.restart = 1'b1; bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.restart = 1'b0; bus.frame_tick = 1'b0;
        check("rst_tick_idx", int'(bus.frame_idx), 0);
        check("rst_tick_adv", int'(bus.frame_adv), 0);
        tick();
        check("rst_cnt_clear", int'(bus.frame_idx), 0);
        tick();
        check("rst_cnt_next", int'(bus.frame_idx), 1);

        // Mode change mid-play is ignored
        do_restart(1'b1, 2'b00, 6'd1);
        bus.mode = 2'b01;
        d0 = done_seen;
        repeat (5) tick();
        idle(1);
        check("mode_ignored_idx", int'(bus.frame_idx), 1);
        check("mode_ignored_done", done_seen - d0, 0);

        // Asynchronous reset between edges at idx 3
        do_restart(1'b1, 2'b00, 6'd1);
        repeat (3) tick();
        check("pre_areset_idx", int'(bus.frame_idx), 3);
        #2 rst_n = 1'b0;
        #1;
        check("areset_idx",  int'(bus.frame_idx), 0);
        check("areset_sel",  int'(bus.frame_sel), 1);
        check("areset_busy", int'(bus.busy), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        tick();
        check("post_areset_idx", int'(bus.frame_idx), 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/anim_frame_sequencer.md
Name: anim_frame_sequencer

Overview:
- Controller that sequences sprite animation frames for the VGA sprite path.
- Advances a frame index once every N video frames, counted on a one-cycle `frame_tick` pulse that is issued once per vsync.
- Supports loop, one-shot and ping-pong playback, plus pause, resume and restart.
- Drives a binary frame index and a one-hot frame select (`animation1`/`animation2`-style enables) to the sprite ROM and colour mapper.

Parameters:
- NUM_FRAMES, 2, number of animation frames (≥1).
- HOLD_W, 6, width of the hold count (video frames per animation frame).
- FRAME_W, $clog2(NUM_FRAMES) (min 1), width of the frame index.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  level; 1 = play, 0 = pause.
- restart  in  1  one-cycle pulse; rewind to frame 0.
- frame_tick  in  1  one-cycle pulse per video frame (vsync).
- mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 treated as loop.
- hold_frames  in  HOLD_W  ticks per animation frame; 0 is treated as 1.
- frame_idx  out  FRAME_W  current frame, registered.
- frame_sel  out  NUM_FRAMES  one-hot of frame_idx, registered.
- frame_adv  out  1  one-cycle pulse when frame_idx changes.
- done  out  1  one-cycle pulse when one-shot completes.
- busy  out  1  1 in PLAY or PAUSE.

Behaviour:
- Reset (async, Reset=0) puts all outputs in this state immediately:
  - state IDLE, frame_idx=0, frame_sel=1 (bit 0 set);
  - frame_adv=0, done=0, busy=0;
  - hold_cnt=0, direction=up.
- States: IDLE, PLAY, PAUSE, DONE.
  - IDLE: outputs hold frame 0. When Run=1, latch mode and hold_frames, clear hold_cnt and go to PLAY. A tick in that same cycle is not counted.
  - PLAY:
    - If Run=0, go to PAUSE. This takes priority over a coincident tick, which is dropped.
    - Otherwise each frame_tick increments hold_cnt.
    - Expiry is a tick while hold_cnt == max(hold,1)-1. On expiry, clear hold_cnt and advance per the latched mode:
      - loop: idx = (idx+1) mod NUM_FRAMES.
      - one-shot: if idx < NUM_FRAMES-1, idx+1. Else idx is unchanged, done pulses and the state goes to DONE (no frame_adv).
      - ping-pong: step in the current direction. Reverse at NUM_FRAMES-1 and at 0, so the endpoints are not repeated. With NUM_FRAMES=1, idx stays 0.
  - PAUSE: hold_cnt, idx and direction are frozen and ticks are ignored. When Run=1, return to PLAY with the same counters.
  - DONE: holds the last frame, busy=0. Run is ignored; only restart leaves DONE.
- restart, from any state, takes priority over tick and Run edges in the same cycle:
  - idx=0, hold_cnt=0, direction=up;
  - re-latch mode and hold_frames;
  - next state is PLAY if Run=1, else IDLE;
  - no frame_adv or done pulse.
- Sampling: mode and hold_frames are sampled only on IDLE→PLAY and on restart. Changes during PLAY or PAUSE are ignored.
- Latency: an expiring tick sampled at edge k produces the new frame_idx, frame_sel and frame_adv=1 after edge k. frame_adv is high for exactly that one cycle.
- frame_sel is always the one-hot of frame_idx in the same cycle; the two never disagree.
- frame_adv pulses on every advance, including a loop wrap from NUM_FRAMES-1 to 0. With NUM_FRAMES=1 in loop mode it still pulses every expiry.
- Back-to-back ticks on consecutive cycles are each counted.

Decomposition:
- Package anim_pkg holds:
  - typedef enum state_t {IDLE, PLAY, PAUSE, DONE};
  - mode constants MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG;
  - a helper function for the one-hot decode.
- Sub-module anim_hold_counter: HOLD_W counter with clear, enable (tick & playing) and an expire output. It applies the 0→1 clamp internally.
- The top level contains the FSM, index/direction logic and output registers.

Test Plan:
- Loop: NUM_FRAMES=4, hold=2, Run=1, 10 ticks → idx after each tick is 0,1,1,2,2,3,3,0,0,1. frame_adv pulses 5×, including the 3→0 wrap. frame_sel tracks idx (1,2,2,4,…).
- One-shot, hold=1, 6 ticks → idx 1,2,3,3,3,3. done pulses once on the 4th tick. busy falls to 0. No frame_adv after idx=3.
- Ping-pong, hold=1, 8 ticks → idx 1,2,3,2,1,0,1,2. Exactly one frame_adv per tick.
- Pause: loop, hold=3, 2 ticks, Run=0, 5 ticks, Run=1, 1 tick → idx goes 0→1 only on that final tick. A tick coincident with Run falling is not counted.
- Edge cases:
  - hold_frames=0 → advance every tick.
  - At idx=2, restart together with a tick → idx=0, hold_cnt=0, no frame_adv.
  - Changing mode mid-PLAY has no effect until restart.
- Reset driven low between clock edges mid-PLAY at idx=3 → outputs clear immediately without a clock edge (idx=0, frame_sel=1, busy=0). After release with Run=1, playback restarts from frame 0.
